sd_cmd_issuer: RTL and testbench

//  Bus master for the SD controller's byte-wide register port (we/addr/data_in/data_out).

---
 rtl/sd_pkg.sv | 35 +++
 rtl/sd_cmd_issuer_if.sv | 42 ++++
 rtl/sd_byte_seq.sv | 64 ++++++
 rtl/sd_cmd_issuer.sv | 247 ++++++++++++++++++++++++
 tb/tb_sd_cmd_issuer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD command issuer.
//  - Byte addresses of the SD controller registers the issuer touches
//    (argument, command, resp0, cmd_isr).
//  - cmd_isr bit positions (CC = command complete, EI = error interrupt).
//  - Issuer state encoding and a helper that forms a register byte address.
package sd_pkg;

    localparam int CMD_REG_SIZE = 14;
    localparam int INT_CMD_SIZE = 5;

    localparam logic [6:0] ADDR_ARGUMENT = 7'h00;
    localparam logic [6:0] ADDR_COMMAND  = 7'h04;
    localparam logic [6:0] ADDR_RESP0    = 7'h08;
    localparam logic [6:0] ADDR_CMD_ISR  = 7'h34;

    localparam int ISR_CC = 0;
    localparam int ISR_EI = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_ARG,
        ST_WAIT,
        ST_POLL,
        ST_RD_RESP,
        ST_CLR,
        ST_DONE
    } issuer_state_t;

    // Register word address (addr[6:2]) plus byte lane -> 7-bit byte address.
    function automatic logic [6:0] reg_byte_addr(input logic [4:0] word, input logic [1:0] sel);
        return {word, sel};
    endfunction

endpackage

// File: rtl/sd_cmd_issuer_if.sv
// Request / result / register-port bundle for the SD command issuer.
//  master modport: the issuer (accepts requests, drives the register port).
//  slave modport : the environment (host sequencer + register slave).
//  Signals:
//   req_valid/req_ready/req_cmd/req_arg         request handshake
//   done_valid/done_status/done_resp/done_timeout result
//   bus_we/bus_addr/bus_wdata/bus_rdata          byte-wide register port
interface sd_cmd_issuer_if
    import sd_pkg::*;
#(
    parameter int CMD_W = CMD_REG_SIZE,
    parameter int ISR_W = INT_CMD_SIZE
) ();

    logic             req_valid;
    logic             req_ready;
    logic [CMD_W-1:0] req_cmd;
    logic [31:0]      req_arg;

    logic             done_valid;
    logic [ISR_W-1:0] done_status;
    logic [31:0]      done_resp;
    logic             done_timeout;

    logic             bus_we;
    logic [6:0]       bus_addr;
    logic [7:0]       bus_wdata;
    logic [7:0]       bus_rdata;

    modport master (
        input  req_valid, req_cmd, req_arg, bus_rdata,
        output req_ready, done_valid, done_status, done_resp, done_timeout,
        output bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output req_valid, req_cmd, req_arg, bus_rdata,
        input  req_ready, done_valid, done_status, done_resp, done_timeout,
        input  bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/sd_byte_seq.sv
// Byte-lane walker shared by the command write, argument write and resp0 read
// phases.
//  i_start    begin a phase; the first lane is 0 (ascending) or 3 (i_desc)
//  i_desc     walk 3,2,1,0 instead of 0,1,2,3
//  i_cnt_m1   number of bytes in the phase minus one
//  i_write    phase is a write phase
//  i_step     advance to the next lane of the running phase
//  o_byte_sel lane to schedule now (valid when i_start or i_step)
//  o_write    write flag of the lane being scheduled
//  o_cur_last lane scheduled on the previous advance was the last of its phase
module sd_byte_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_desc,
    input  logic [1:0] i_cnt_m1,
    input  logic       i_write,
    input  logic       i_step,
    output logic [1:0] o_byte_sel,
    output logic       o_write,
    output logic       o_cur_last
);

    logic [1:0] r_idx;
    logic [1:0] r_left;
    logic       r_desc;
    logic       r_write;
    logic       r_cur_last;

    logic [1:0] w_idx;
    logic [1:0] w_left;
    logic       w_desc;
    logic       w_write;

    // A start overrides the running phase so the first lane is available in
    // the same cycle the phase is requested.
    always_comb begin
        w_idx   = i_start ? (i_desc ? 2'd3 : 2'd0) : r_idx;
        w_left  = i_start ? i_cnt_m1 : r_left;
        w_desc  = i_start ? i_desc   : r_desc;
        w_write = i_start ? i_write  : r_write;
    end

    assign o_byte_sel = w_idx;
    assign o_write    = w_write;
    assign o_cur_last = r_cur_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= 2'd0;
            r_left     <= 2'd0;
            r_desc     <= 1'b0;
            r_write    <= 1'b0;
            r_cur_last <= 1'b0;
        end else if (i_start || i_step) begin
            r_idx      <= w_desc ? w_idx - 2'd1 : w_idx + 2'd1;
            r_left     <= w_left - 2'd1;
            r_desc     <= w_desc;
            r_write    <= w_write;
            r_cur_last <= (w_left == 2'd0);
        end
    end

endmodule

// File: rtl/sd_cmd_issuer.sv
// SD command issuer: bus master on the SD controller's byte-wide register port.
// Writes the command register (bytes 0,1), the argument register (bytes
// 3,2,1,0 -- byte 0 starts the command), polls cmd_isr every POLL_GAP idle
// cycles until CC or EI (or POLL_MAX reads), reads resp0, clears cmd_isr and
// pulses done_valid with the status / response.
//  clk, rst : clock, synchronous active-high reset
//  bif      : sd_cmd_issuer_if.master (request, result and register port)
// The state register names the bus access being performed in the current
// cycle, so each transition also loads the registered bus outputs for the
// access that follows.
module sd_cmd_issuer
    import sd_pkg::*;
#(
    parameter int CMD_W    = CMD_REG_SIZE,
    parameter int ISR_W    = INT_CMD_SIZE,
    parameter int POLL_GAP = 8,
    parameter int POLL_MAX = 65535
) (
    input logic             clk,
    input logic             rst,
    sd_cmd_issuer_if.master bif
);

    localparam logic [15:0] GAP_LAST   = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);
    localparam logic [6:0]  ISR_ADDR   = reg_byte_addr(ADDR_CMD_ISR[6:2], 2'd0);

    issuer_state_t    r_state;
    logic [15:0]      r_cmd;
    logic [31:0]      r_arg;
    logic [15:0]      r_poll_cnt;
    logic [15:0]      r_gap_cnt;
    logic             r_req_ready;
    logic             r_done_valid;
    logic [ISR_W-1:0] r_done_status;
    logic [31:0]      r_done_resp;
    logic             r_done_timeout;
    logic             r_bus_we;
    logic [6:0]       r_bus_addr;
    logic [7:0]       r_bus_wdata;

    logic        w_accept;
    logic        w_isr_hit;
    logic [15:0] w_poll_inc;
    logic        w_seq_start;
    logic        w_seq_desc;
    logic [1:0]  w_seq_cnt_m1;
    logic        w_seq_write_in;
    logic        w_seq_step;
    logic [1:0]  w_seq_sel;
    logic        w_seq_we;
    logic        w_seq_last;
    logic [4:0]  w_seq_base;
    logic [31:0] w_wr_src;
    logic [6:0]  w_seq_addr;
    logic [7:0]  w_seq_wdata;

    sd_byte_seq u_seq (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_seq_start),
        .i_desc     (w_seq_desc),
        .i_cnt_m1   (w_seq_cnt_m1),
        .i_write    (w_seq_write_in),
        .i_step     (w_seq_step),
        .o_byte_sel (w_seq_sel),
        .o_write    (w_seq_we),
        .o_cur_last (w_seq_last)
    );

    always_comb begin
        w_accept       = bif.req_valid && r_req_ready;
        w_isr_hit      = bif.bus_rdata[ISR_CC] | bif.bus_rdata[ISR_EI];
        w_poll_inc     = (r_poll_cnt == 16'hFFFF) ? r_poll_cnt : r_poll_cnt + 16'd1;
        w_seq_start    = 1'b0;
        w_seq_desc     = 1'b0;
        w_seq_cnt_m1   = 2'd3;
        w_seq_write_in = 1'b0;
        w_seq_step     = 1'b0;
        w_seq_base     = ADDR_COMMAND[6:2];
        w_wr_src       = 32'h0;
        case (r_state)
            ST_IDLE: begin
                // Command byte 0 is scheduled straight from the request port.
                w_seq_start    = w_accept;
                w_seq_cnt_m1   = 2'd1;
                w_seq_write_in = 1'b1;
                w_wr_src       = {16'h0, 16'(bif.req_cmd)};
            end
            ST_WR_CMD: begin
                if (w_seq_last) begin
                    w_seq_start    = 1'b1;
                    w_seq_desc     = 1'b1;
                    w_seq_write_in = 1'b1;
                    w_seq_base     = ADDR_ARGUMENT[6:2];
                    w_wr_src       = r_arg;
                end else begin
                    w_seq_step = 1'b1;
                    w_wr_src   = {16'h0, r_cmd};
                end
            end
            ST_WR_ARG: begin
                w_seq_step = !w_seq_last;
                w_seq_base = ADDR_ARGUMENT[6:2];
                w_wr_src   = r_arg;
            end
            ST_POLL: begin
                w_seq_start = w_isr_hit;
                w_seq_base  = ADDR_RESP0[6:2];
            end
            ST_RD_RESP: begin
                w_seq_step = !w_seq_last;
                w_seq_base = ADDR_RESP0[6:2];
            end
            default: ;
        endcase
        w_seq_addr  = reg_byte_addr(w_seq_base, w_seq_sel);
        w_seq_wdata = w_wr_src[{w_seq_sel, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cmd          <= 16'h0;
            r_arg          <= 32'h0;
            r_poll_cnt     <= 16'h0;
            r_gap_cnt      <= 16'h0;
            r_req_ready    <= 1'b1;
            r_done_valid   <= 1'b0;
            r_done_status  <= '0;
            r_done_resp    <= 32'h0;
            r_done_timeout <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= 7'h0;
            r_bus_wdata    <= 8'h0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd          <= 16'(bif.req_cmd);
                        r_arg          <= bif.req_arg;
                        r_poll_cnt     <= 16'h0;
                        r_done_timeout <= 1'b0;
                        r_req_ready    <= 1'b0;
                        r_bus_we       <= w_seq_we;
                        r_bus_addr     <= w_seq_addr;
                        r_bus_wdata    <= w_seq_wdata;
                        r_state        <= ST_WR_CMD;
                    end
                end
                ST_WR_CMD: begin
                    r_bus_we    <= w_seq_we;
                    r_bus_addr  <= w_seq_addr;
                    r_bus_wdata <= w_seq_wdata;
                    if (w_seq_last) r_state <= ST_WR_ARG;
                end
                ST_WR_ARG: begin
                    if (w_seq_last) begin
                        r_bus_we    <= 1'b0;
                        r_bus_wdata <= 8'h0;
                        r_gap_cnt   <= 16'h0;
                        if (POLL_GAP == 0) begin
                            r_bus_addr <= ISR_ADDR;
                            r_state    <= ST_POLL;
                        end else begin
                            r_bus_addr <= 7'h0;
                            r_state    <= ST_WAIT;
                        end
                    end else begin
                        r_bus_we    <= w_seq_we;
                        r_bus_addr  <= w_seq_addr;
                        r_bus_wdata <= w_seq_wdata;
                    end
                end
                ST_WAIT: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_bus_addr <= ISR_ADDR;
                        r_state    <= ST_POLL;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                ST_POLL: begin
                    r_done_status <= bif.bus_rdata[ISR_W-1:0];
                    r_poll_cnt    <= w_poll_inc;
                    if (w_isr_hit) begin
                        // CC and EI together still count as completion.
                        r_bus_we    <= w_seq_we;
                        r_bus_addr  <= w_seq_addr;
                        r_bus_wdata <= w_seq_wdata;
                        r_state     <= ST_RD_RESP;
                    end else if (w_poll_inc == POLL_LIMIT) begin
                        r_done_timeout <= 1'b1;
                        r_done_resp    <= 32'h0;
                        r_bus_we       <= 1'b1;
                        r_bus_addr     <= ISR_ADDR;
                        r_bus_wdata    <= 8'h0;
                        r_state        <= ST_CLR;
                    end else if (POLL_GAP == 0) begin
                        r_bus_addr <= ISR_ADDR;
                    end else begin
                        r_bus_addr <= 7'h0;
                        r_gap_cnt  <= 16'h0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_RD_RESP: begin
                    // The lane just read is the low two bits of the address on the bus.
                    r_done_resp[{r_bus_addr[1:0], 3'b000} +: 8] <= bif.bus_rdata;
                    if (w_seq_last) begin
                        r_bus_we    <= 1'b1;
                        r_bus_addr  <= ISR_ADDR;
                        r_bus_wdata <= 8'h0;
                        r_state     <= ST_CLR;
                    end else begin
                        r_bus_we    <= w_seq_we;
                        r_bus_addr  <= w_seq_addr;
                        r_bus_wdata <= w_seq_wdata;
                    end
                end
                ST_CLR: begin
                    r_bus_we     <= 1'b0;
                    r_bus_addr   <= 7'h0;
                    r_bus_wdata  <= 8'h0;
                    r_done_valid <= 1'b1;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bif.req_ready    = r_req_ready;
    assign bif.done_valid   = r_done_valid;
    assign bif.done_status  = r_done_status;
    assign bif.done_resp    = r_done_resp;
    assign bif.done_timeout = r_done_timeout;
    assign bif.bus_we       = r_bus_we;
    assign bif.bus_addr     = r_bus_addr;
    assign bif.bus_wdata    = r_bus_wdata;

endmodule

// File: tb/tb_sd_cmd_issuer.sv
// Bench for sd_cmd_issuer with POLL_GAP=2, POLL_MAX=4.
// A behavioural register slave answers cmd_isr with a scripted value on the
// k-th read (k=0: never) and returns a chosen resp0. Expectations (write list,
// poll count, latency, result fields) come from the transaction description.
module tb_sd_cmd_issuer;

    localparam int GAP  = 2;
    localparam int PMAX = 4;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    int          sc_k = 0;
    logic [4:0]  sc_isr = 5'h0;
    logic [31:0] sc_resp = 32'h0;
    int          sl_polls = 0;

    wr_t wlog[$];
    int  mon_polls = 0;
    int  mon_done = 0;

    sd_cmd_issuer_if #(.CMD_W(14), .ISR_W(5)) bif ();

    sd_cmd_issuer #(.CMD_W(14), .ISR_W(5), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register slave: cmd_isr read counter restarts on the clear write.
    always @(posedge clk) begin
        if (rst) sl_polls <= 0;
        else if (bif.bus_we && bif.bus_addr == 7'h34) sl_polls <= 0;
        else if (!bif.bus_we && bif.bus_addr == 7'h34) sl_polls <= sl_polls + 1;
    end

    always_comb begin
        case (bif.bus_addr)
            7'h08:   bif.bus_rdata = sc_resp[7:0];
            7'h09:   bif.bus_rdata = sc_resp[15:8];
            7'h0A:   bif.bus_rdata = sc_resp[23:16];
            7'h0B:   bif.bus_rdata = sc_resp[31:24];
            7'h34:   bif.bus_rdata = (sc_k != 0 && sl_polls + 1 >= sc_k) ? {3'b000, sc_isr} : 8'h00;
            default: bif.bus_rdata = 8'h5A;
        endcase
    end

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.bus_we) wlog.push_back('{bif.bus_addr, bif.bus_wdata, cyc});
            if (!bif.bus_we && bif.bus_addr == 7'h34) mon_polls++;
            if (bif.done_valid) mon_done++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag, input int wb, input logic [13:0] cmd,
                                input logic [31:0] arg);
        logic [6:0] ea[7];
        logic [7:0] ed[7];
        logic [15:0] c16;
        c16 = {2'b00, cmd};
        ea[0] = 7'h04; ed[0] = c16[7:0];
        ea[1] = 7'h05; ed[1] = c16[15:8];
        ea[2] = 7'h03; ed[2] = arg[31:24];
        ea[3] = 7'h02; ed[3] = arg[23:16];
        ea[4] = 7'h01; ed[4] = arg[15:8];
        ea[5] = 7'h00; ed[5] = arg[7:0];
        ea[6] = 7'h34; ed[6] = 8'h00;
        check($sformatf("%s.nwrites", tag), 64'(wlog.size() - wb), 64'd7);
        for (int i = 0; i < 7; i++) begin
            if (wb + i < wlog.size())
                check($sformatf("%s.wr%0d", tag, i), {wlog[wb+i].a, wlog[wb+i].d}, {ea[i], ed[i]});
        end
    endtask

    task automatic wait_done(output bit seen);
        int n;
        n = 0;
        while (!bif.done_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        seen = bif.done_valid;
    endtask

    task automatic run_txn(input string tag, input logic [13:0] cmd, input logic [31:0] arg,
                           input int k, input logic [4:0] isr, input logic [31:0] resp,
                           input bit hold, output int done_at);
        int  polls, lat, wb, pb, db, acc, n;
        bit  to, seen;
        sc_k = k; sc_isr = isr; sc_resp = resp;
        to    = !(k >= 1 && k <= PMAX);
        polls = to ? PMAX : k;
        lat   = (to ? 8 : 12) + polls * (GAP + 1);
        n = 0;
        while (!bif.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".ready_idle"}, 64'(bif.req_ready), 64'd1);
        wb = wlog.size(); pb = mon_polls; db = mon_done;
        bif.req_cmd = cmd; bif.req_arg = arg; bif.req_valid = 1'b1;
        acc = cyc;
        @(negedge clk);
        check({tag, ".ready_drop"}, 64'(bif.req_ready), 64'd0);
        if (!hold) bif.req_valid = 1'b0;
        wait_done(seen);
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
        done_at = cyc;
        check({tag, ".latency"}, 64'(cyc - acc), 64'(lat));
        check({tag, ".status"}, 64'(bif.done_status), 64'(to ? 5'h0 : isr));
        check({tag, ".resp"}, 64'(bif.done_resp), 64'(to ? 32'h0 : resp));
        check({tag, ".timeout"}, 64'(bif.done_timeout), 64'(to));
        check({tag, ".ready_at_done"}, 64'(bif.req_ready), 64'd0);
        @(negedge clk);
        check({tag, ".pulse_end"}, 64'(bif.done_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(bif.req_ready), 64'd1);
        check({tag, ".npulses"}, 64'(mon_done - db), 64'd1);
        check({tag, ".npolls"}, 64'(mon_polls - pb), 64'(polls));
        check_writes(tag, wb, cmd, arg);
        if (wb < wlog.size())
            check({tag, ".first_wr_cyc"}, 64'(wlog[wb].c - acc), 64'd1);
    endtask

    initial begin
        int          d0, d1, acc2, wb2, db2;
        bit          seen;
        logic [13:0] rc;
        logic [31:0] ra, rr;
        logic [4:0]  ri;
        int          rk;

        bif.req_valid = 1'b0;
        bif.req_cmd   = '0;
        bif.req_arg   = '0;
        repeat (3) @(negedge clk);
        check("rst.ready", 64'(bif.req_ready), 64'd1);
        check("rst.done_valid", 64'(bif.done_valid), 64'd0);
        check("rst.status", 64'(bif.done_status), 64'd0);
        check("rst.resp", 64'(bif.done_resp), 64'd0);
        check("rst.timeout", 64'(bif.done_timeout), 64'd0);
        check("rst.bus", {bif.bus_we, bif.bus_addr, bif.bus_wdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: CC on 3rd poll.
        run_txn("t1", 14'h0119, 32'hDEADBEEF, 3, 5'h01, 32'h12345678, 1'b0, d0);
        // 2: CC on 1st poll, resp0 = 0x900.
        run_txn("t2", 14'h0008, 32'h000001AA, 1, 5'h01, 32'h00000900, 1'b0, d0);
        // 3: error interrupt only.
        run_txn("t3", 14'h0237, 32'h00000000, 1, 5'h02, 32'hCAFEF00D, 1'b0, d0);
        // CC and EI together.
        run_txn("t3b", 14'h3FFF, 32'hFFFFFFFF, 2, 5'h03, 32'hA5A5A5A5, 1'b0, d0);
        // 4: status never set -> timeout after POLL_MAX reads.
        run_txn("t4", 14'h0101, 32'h01020304, 0, 5'h01, 32'h87654321, 1'b0, d0);

        // 5: req_valid held; next accept only on the cycle after done_valid.
        run_txn("t5a", 14'h0A0B, 32'h11223344, 1, 5'h01, 32'h55667788, 1'b1, d0);
        acc2 = cyc; wb2 = wlog.size(); db2 = mon_done;
        check("t5.accept_cycle", 64'(acc2 - d0), 64'd1);
        @(negedge clk);
        bif.req_valid = 1'b0;
        check("t5b.ready_drop", 64'(bif.req_ready), 64'd0);
        wait_done(seen);
        d1 = cyc;
        check("t5b.done_seen", 64'(seen), 64'd1);
        check("t5b.latency", 64'(d1 - acc2), 64'(12 + (GAP + 1)));
        check("t5b.resp", 64'(bif.done_resp), 64'h55667788);
        @(negedge clk);
        check("t5b.npulses", 64'(mon_done - db2), 64'd1);
        check_writes("t5b", wb2, 14'h0A0B, 32'h11223344);
        if (wb2 < wlog.size())
            check("t5b.first_wr_cyc", 64'(wlog[wb2].c - d0), 64'd2);

        // 6: reset during WAIT.
        sc_k = 0;
        bif.req_cmd = 14'h0155; bif.req_arg = 32'h0BADF00D; bif.req_valid = 1'b1;
        @(negedge clk);
        bif.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("t6.in_wait_idle", 64'(bif.bus_we), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6.ready", 64'(bif.req_ready), 64'd1);
        check("t6.done", {bif.done_valid, bif.done_timeout}, 64'd0);
        check("t6.status", 64'(bif.done_status), 64'd0);
        check("t6.resp", 64'(bif.done_resp), 64'd0);
        check("t6.bus", {bif.bus_we, bif.bus_addr, bif.bus_wdata}, 64'd0);
        wb2 = wlog.size(); db2 = mon_done;
        repeat (30) @(negedge clk);
        check("t6.no_writes", 64'(wlog.size() - wb2), 64'd0);
        check("t6.no_done", 64'(mon_done - db2), 64'd0);

        // Randomized requests.
        for (int i = 0; i < 8; i++) begin
            rc = 14'($urandom);
            ra = $urandom;
            rr = $urandom;
            ri = 5'($urandom_range(0, 31));
            if (ri[1:0] == 2'b00) ri[0] = 1'b1;
            rk = $urandom_range(0, 5);
            run_txn($sformatf("rnd%0d", i), rc, ra, rk, ri, rr, 1'b0, d0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
